// File: rtl/ifns_6di_decoder.sv
// ---------------------------------------------------------------------------
// ifns_6di_decoder
//
// Receive-side decoder for the 8-wire IFNS crosstalk-avoidance code produced
// by the 6-bit IFNS encoder. The data word is rebuilt as the weighted sum of
// the codeword bits (d8..d1 = 34,13,8,5,3,2,1,1). Sums above 63 are flagged
// as range errors. The sum is computed in two pipeline stages with
// valid/ready handshakes on both sides.
//
// Optional feature (macro IFNS_DEC_FTF_CHECK_EN): flags forbidden adjacent-
// wire transitions between consecutive accepted codewords. When the macro is
// undefined, the previous-codeword register and the check are absent, and
// out_ftf_err is always 0.
//
// Parameters:
//   PREV_INIT   previous-codeword value loaded at reset/flush (ftf check)
//   SAT_ON_ERR  1: out_data = 63 on range error; 0: out_data = sum mod 64
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            asynchronous active-high reset
//   flush          synchronous clear of pipeline valids and previous codeword
//   in_valid       in_code is valid
//   in_ready       decoder can accept in_code this cycle (combinational)
//   in_code[7:0]   codeword, bit7 = d8 ... bit0 = d1
//   out_valid      out_data / out_range_err / out_ftf_err are valid
//   out_ready      consumer accepts the output this cycle
//   out_data[5:0]  decoded value
//   out_range_err  weighted sum > 63
//   out_ftf_err    forbidden transition versus previous accepted codeword
// ---------------------------------------------------------------------------
module ifns_6di_decoder #(
  parameter logic [7:0] PREV_INIT  = 8'h00,
  parameter bit         SAT_ON_ERR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_data,
  output logic       out_range_err,
  output logic       out_ftf_err
);

  // Stage 1 registers
  logic       s1_valid_r;
  logic [5:0] hi_r;
  logic [3:0] lo_r;
  logic       s1_ftf_r;

  // Output registers
  logic       out_valid_r;
  logic [5:0] out_data_r;
  logic       out_range_err_r;
  logic       out_ftf_err_r;

  // Combinational control and datapath
  logic       in_ready_s;
  logic       accept_s;
  logic       s1_load_s;
  logic       s2_load_s;
  logic [5:0] hi_s;
  logic [3:0] lo_s;
  logic [6:0] sum_s;
  logic       range_err_s;
  logic [5:0] data_s;
  logic       ftf_s;

  // The only blocking case is both stages full with the consumer stalled.
  assign in_ready_s = !flush && !(s1_valid_r && out_valid_r && !out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign s2_load_s  = s1_valid_r && (!out_valid_r || out_ready);
  assign s1_load_s  = accept_s && (!s1_valid_r || s2_load_s);

  // Upper partial sum fits 6 bits (max 55), lower fits 4 bits (max 12).
  assign hi_s = (in_code[7] ? 6'd34 : 6'd0)
              + (in_code[6] ? 6'd13 : 6'd0)
              + (in_code[5] ? 6'd8  : 6'd0);
  assign lo_s = (in_code[4] ? 4'd5 : 4'd0)
              + (in_code[3] ? 4'd3 : 4'd0)
              + (in_code[2] ? 4'd2 : 4'd0)
              + (in_code[1] ? 4'd1 : 4'd0)
              + (in_code[0] ? 4'd1 : 4'd0);

  // Full 7-bit sum so the range compare sees values up to 67.
  assign sum_s       = {1'b0, hi_r} + {3'b000, lo_r};
  assign range_err_s = (sum_s > 7'd63);
  assign data_s      = (range_err_s && SAT_ON_ERR) ? 6'd63 : sum_s[5:0];

`ifdef IFNS_DEC_FTF_CHECK_EN
  logic [7:0] prev_r;

  // Two neighbouring wires toggling in opposite directions is forbidden.
  function automatic logic ftf_check(input logic [7:0] prev, input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 7; i++) begin
      hit = hit
          | (prev[i] & ~code[i] & ~prev[i+1] &  code[i+1])
          | (~prev[i] & code[i] &  prev[i+1] & ~code[i+1]);
    end
    return hit;
  endfunction

  assign ftf_s = ftf_check(prev_r, in_code);

  // Previous accepted codeword, restarted from PREV_INIT on reset/flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r <= PREV_INIT;
    end else if (flush) begin
      prev_r <= PREV_INIT;
    end else if (accept_s) begin
      prev_r <= in_code;
    end else begin
      prev_r <= prev_r;
    end
  end
`else
  logic unused_prev_init_s;

  assign unused_prev_init_s = ^PREV_INIT;
  assign ftf_s              = 1'b0;
`endif

  // Stage 1: capture the partial sums and transition flag of an accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      hi_r       <= 6'd0;
      lo_r       <= 4'd0;
      s1_ftf_r   <= 1'b0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      hi_r       <= hi_s;
      lo_r       <= lo_s;
      s1_ftf_r   <= ftf_s;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: final sum, range check and output registers (held while stalled)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r     <= 1'b0;
      out_data_r      <= 6'd0;
      out_range_err_r <= 1'b0;
      out_ftf_err_r   <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (s2_load_s) begin
      out_valid_r     <= 1'b1;
      out_data_r      <= data_s;
      out_range_err_r <= range_err_s;
      out_ftf_err_r   <= s1_ftf_r;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready      = in_ready_s;
  assign out_valid     = out_valid_r;
  assign out_data      = out_data_r;
  assign out_range_err = out_range_err_r;
  assign out_ftf_err   = out_ftf_err_r;

endmodule

// File: tb/tb_ifns_6di_decoder.sv
// ---------------------------------------------------------------------------
// Testbench for ifns_6di_decoder: directed vector tables, hand-written stall,
// flush and reset sequences, and a randomized phase. A negedge monitor keeps
// a scoreboard of accepted words, predicted from the weight table, and checks
// every output handshake, in_ready and output stability under backpressure.
// ---------------------------------------------------------------------------
module tb_ifns_6di_decoder;

  localparam logic [7:0] PREV_INIT  = 8'h00;
  localparam bit         SAT_ON_ERR = 1'b1;
`ifdef IFNS_DEC_FTF_CHECK_EN
  localparam bit FTF_ON = 1'b1;
`else
  localparam bit FTF_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;
  logic       out_range_err;
  logic       out_ftf_err;

  ifns_6di_decoder #(
    .PREV_INIT  (PREV_INIT),
    .SAT_ON_ERR (SAT_ON_ERR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_code       (in_code),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_range_err (out_range_err),
    .out_ftf_err   (out_ftf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic [5:0] data;
    logic       rerr;
    logic       ftf;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t       tab [13];
  exp_t       sb_q [$];
  logic [7:0] model_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: weighted sum from the weight table, transitions as
  // "both neighbours toggle and end up different".
  function automatic exp_t model(input logic [7:0] code, input logic [7:0] prev);
    exp_t r;
    int   w [8];
    int   sum;
    w   = '{1, 1, 2, 3, 5, 8, 13, 34};
    sum = 0;
    for (int i = 0; i < 8; i++) if (code[i]) sum += w[i];
    r.code = code;
    r.rerr = (sum > 63);
    if (r.rerr && SAT_ON_ERR) r.data = 6'd63;
    else                      r.data = 6'(sum % 64);
    r.ftf = 1'b0;
    if (FTF_ON) begin
      for (int i = 0; i < 7; i++) begin
        if ((code[i] != prev[i]) && (code[i+1] != prev[i+1]) && (code[i] != code[i+1]))
          r.ftf = 1'b1;
      end
    end
    return r;
  endfunction

  // Monitor state
  logic       exp_rdy;
  logic       hold_pending;
  logic [5:0] hold_data;
  logic       hold_rerr;
  logic       hold_ftf;
  exp_t       pop_e;

  // Scoreboard monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      model_prev   = PREV_INIT;
      hold_pending = 1'b0;
      check("rst_out_valid", out_valid, 1'b0);
    end else if (flush) begin
      check("flush_in_ready", in_ready, 1'b0);
      sb_q.delete();
      model_prev   = PREV_INIT;
      hold_pending = 1'b0;
    end else begin
      exp_rdy = !((sb_q.size() == 2) && !out_ready);
      check("in_ready", in_ready, exp_rdy);
      if (hold_pending) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, hold_data);
        check("hold_rerr", out_range_err, hold_rerr);
        check("hold_ftf", out_ftf_err, hold_ftf);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("pop_with_empty_scoreboard", out_valid, 1'b0);
        end else begin
          pop_e = sb_q.pop_front();
          check("sb_data", out_data, pop_e.data);
          check("sb_rerr", out_range_err, pop_e.rerr);
          check("sb_ftf", out_ftf_err, pop_e.ftf);
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(in_code, model_prev));
        model_prev = in_code;
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      hold_rerr    = out_range_err;
      hold_ftf     = out_ftf_err;
    end
  end

  // Stream table entries back-to-back with out_ready high; each output must
  // appear exactly two cycles after its accept, on consecutive cycles.
  task automatic run_table(input int first, input int last, input bit chk_ftf);
    int   n;
    exp_t e;
    n = last - first + 1;
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (i < n) begin
        in_valid = 1'b1;
        in_code  = tab[first + i].code;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i == 1) check("latency_not_early", out_valid, 1'b0);
      if (i >= 2) begin
        e = tab[first + i - 2];
        check("tab_valid", out_valid, 1'b1);
        check("tab_data", out_data, e.data);
        check("tab_rerr", out_range_err, e.rerr);
        if (chk_ftf) check("tab_ftf", out_ftf_err, e.ftf);
      end
    end
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  logic [7:0] sc [3];
  logic [5:0] got [$];
  int         k;

  initial begin
    tab[0]  = '{8'h80, 6'd34, 1'b0, 1'b0};
    tab[1]  = '{8'h55, 6'd21, 1'b0, 1'b0};
    tab[2]  = '{8'h03, 6'd2,  1'b0, 1'b0};
    tab[3]  = '{8'h00, 6'd0,  1'b0, 1'b0};
    tab[4]  = '{8'hFF, SAT_ON_ERR ? 6'd63 : 6'd3, 1'b1, 1'b0};
    tab[5]  = '{8'hFC, SAT_ON_ERR ? 6'd63 : 6'd1, 1'b1, 1'b0};
    tab[6]  = '{8'h7F, 6'd33, 1'b0, 1'b0};
    tab[7]  = '{8'hE0, 6'd55, 1'b0, 1'b0};
    tab[8]  = '{8'h01, 6'd1,  1'b0, 1'b0};
    tab[9]  = '{8'h02, 6'd1,  1'b0, FTF_ON};
    tab[10] = '{8'h03, 6'd2,  1'b0, 1'b0};
    tab[11] = '{8'h01, 6'd1,  1'b0, 1'b0};
    tab[12] = '{8'h02, 6'd1,  1'b0, 1'b0};
    sc[0] = 8'h01; sc[1] = 8'h04; sc[2] = 8'h08;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_code = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 6'd0);
    check("reset_range_err", out_range_err, 1'b0);
    check("reset_ftf_err", out_ftf_err, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors, then transition-check vectors starting from PREV_INIT
    run_table(0, 7, 1'b0);
    do_flush();
    run_table(8, 11, 1'b1);

    // Backpressure: three words with the consumer stalled
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_code = sc[0]; k = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_hold_data", out_data, 6'd1);
      end
      if (in_valid && in_ready) k++;
      @(posedge clk); #1;
      if (k < 3) in_code = sc[k];
      else       in_valid = 1'b0;
    end
    check("stall_accepts", k, 2);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) k++;
      if (out_valid && out_ready) got.push_back(out_data);
      @(posedge clk); #1;
      if (k >= 3) in_valid = 1'b0;
    end
    check("stall_out_count", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) check("stall_out_order", got[i], 6'(i + 1));
    end

    // Flush with both stages full and a word offered at the same time
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_code = 8'h10;
    @(posedge clk); #1;
    in_code = 8'h01;
    @(posedge clk); #1;
    flush = 1'b1; in_code = 8'h02;
    @(negedge clk);
    check("flush_pending_out", out_valid, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_cleared", out_valid, 1'b0);
    @(negedge clk);
    check("flush_s1_cleared", out_valid, 1'b0);
    run_table(12, 12, 1'b1);

    // Asynchronous reset with words in flight
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_code = 8'h20;
    @(posedge clk); #1;
    in_code = 8'h40;
    @(posedge clk); #2;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);

    // Randomized traffic with backpressure and occasional flush
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_code   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (sb_q.size() == 0) break;
    end
    check("drain_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifns_6di_decoder.md
Name: ifns_6di_decoder

Overview:
- Receive-side decoder for the 8-wire IFNS crosstalk-avoidance code produced by the 6-bit IFNS encoder core.
- Reconstructs the 6-bit data word as the weighted sum of the codeword bits.
- Flags codewords whose sum is out of range. Optionally flags forbidden adjacent-wire transitions between consecutive codewords.
- Two-stage pipeline with valid/ready handshakes on both sides; sits between the bus receiver flops and the consumer.

Parameters:
- PREV_INIT, 8'h00, previous-codeword value loaded at reset/flush for the transition check.
- SAT_ON_ERR, 1, 1: out_data saturates to 6'd63 on range error; 0: out_data = sum mod 64.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of pipeline valids and previous-codeword register.
- in_valid  input  1  in_code is valid.
- in_ready  output  1  decoder can accept in_code this cycle.
- in_code  input  8  codeword; bit7=d8 ... bit0=d1.
- out_valid  output  1  out_data/out_range_err/out_ftf_err valid.
- out_ready  input  1  consumer accepts output this cycle.
- out_data  output  6  decoded value.
- out_range_err  output  1  weighted sum > 63.
- out_ftf_err  output  1  forbidden transition versus previous accepted codeword (0 when feature is compiled out).

Behaviour:
- Weights: d8=34, d7=13, d6=8, d5=5, d4=3, d3=2, d2=1, d1=1; maximum sum 67.
- Accept: in_valid && in_ready && !flush.
- Stage 1 (on accept): register hi = 34*d8 + 13*d7 + 8*d6 (6 bits, max 55) and lo = 5*d5 + 3*d4 + 2*d3 + d2 + d1 (4 bits, max 12). Register the ftf flag. Set s1_valid.
- Stage 2: sum = hi + lo, 7 bits unsigned, no truncation before compare.
  - range_err = (sum > 63).
  - out_data = range_err ? (SAT_ON_ERR ? 63 : sum[5:0]) : sum[5:0].
  - Registered into the output regs; out_valid set.
- Latency: exactly 2 cycles from accept to out_valid when unstalled. Throughput 1 word/cycle.
- Stall rules:
  - Stage 2 loads when s1_valid && (!out_valid || out_ready).
  - Stage 1 loads on accept when !s1_valid or stage 2 loads in the same cycle.
  - in_ready = !flush && !(s1_valid && out_valid && !out_ready). Combinational; does not depend on in_valid.
  - Output regs hold stable while out_valid && !out_ready.
  - No word dropped or duplicated; order preserved.
- out_valid clears when out_ready is high and stage 2 does not reload.
- Flush: next edge clears s1_valid and out_valid and loads prev = PREV_INIT. Flush has priority over a simultaneous in_valid (not accepted) and over a pending output (discarded).
- Reset (async): s1_valid=0, out_valid=0, out_data=0, out_range_err=0, out_ftf_err=0, hi/lo=0, prev=PREV_INIT.
- Reset mid-stall: all in-flight words are lost; in_ready is high the first cycle after rst deasserts.
- Data regs may hold stale values when the associated valid is 0; consumers must qualify with out_valid.

Optional Feature:
- Macro: IFNS_DEC_FTF_CHECK_EN.
- Defined:
  - Keep register prev (8 bits), updated with in_code on every accept.
  - ftf = OR over i=0..6 of (prev[i] & ~in_code[i] & ~prev[i+1] & in_code[i+1]) | (~prev[i] & in_code[i] & prev[i+1] & ~in_code[i+1]).
  - The flag travels with its word to out_ftf_err. The first word after reset/flush compares against PREV_INIT.
- Not defined: prev and the check logic are absent; out_ftf_err is tied to 0. All other behaviour is unchanged.

Test Plan:
- Reset, then in_code=8'b10000000 with out_ready=1 -> out_valid exactly 2 cycles after accept, out_data=34, errs=0.
- Back-to-back 8'b01010101, 8'b00000011, 8'b00000000, out_ready=1 -> outputs 21, 2, 0 on consecutive cycles.
- in_code=8'hFF -> out_range_err=1, out_data=63 (SAT_ON_ERR=1) / 3 (SAT_ON_ERR=0). in_code=8'b11111100 -> err=1, sum 65.
- out_ready=0 while sending 3 codewords (values 1, 2, 3) -> in_ready drops after 2 accepts, output holds 1 stable. Release out_ready -> 1, 2, 3 in order, no loss.
- With IFNS_DEC_FTF_CHECK_EN: send 8'b00000001 then 8'b00000010 -> second output has out_ftf_err=1. Send 8'b00000011 then 8'b00000001 -> out_ftf_err=0.
- Assert flush with one word in each stage and in_valid=1 -> next cycle out_valid=0, s1 empty, input not accepted. Next codeword's ftf check is against PREV_INIT.
